// File: rtl/md5_sched_pkg.sv
// Shared definitions for the MD5 core scheduler: state encoding, size limits, helpers.
// The optional statistics counters are enabled with `define MD5_SCHED_STATS_EN.
package md5_sched_pkg;

  localparam int unsigned MsgWDefault = 128;
  localparam int unsigned NCoresMax   = 8;
  localparam int unsigned StatsW      = 48;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFound
  } sched_state_e;

  function automatic int unsigned popcount(input logic [NCoresMax-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(NCoresMax); i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer;
// on advance the pointer moves to the slot after the granted one, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_off;
  logic [PtrW-1:0] w_grant_idx;
  logic [PtrW:0]   w_sum;
  logic [N-1:0]    w_rot;
  logic            w_any;

  always_comb begin
    // Rotate so that bit 0 is the highest-priority slot.
    w_rot = N'({i_req, i_req} >> r_ptr);
    w_any = 1'b0;
    w_off = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_off = PtrW'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (PtrW + 1)'(N)) begin
      w_sum = w_sum - (PtrW + 1)'(N);
    end
    w_grant_idx = w_sum[PtrW-1:0];
    o_grant     = w_any ? (N'(1) << w_grant_idx) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance && w_any) begin
      r_ptr <= (w_grant_idx == PtrW'(N - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/md5_core_scheduler.sv
// Distributes candidate messages round-robin over NCORES hash cores and reports the first
// candidate whose digest matches the target. Define MD5_SCHED_STATS_EN to add counters.
module md5_core_scheduler
  import md5_sched_pkg::*;
#(
  parameter int unsigned NCORES = 2,
  parameter int unsigned MSG_W  = MsgWDefault
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    clear,
  input  logic [MSG_W-1:0]        target,
  input  logic                    cand_valid,
  output logic                    cand_ready,
  input  logic [MSG_W-1:0]        cand_data,
  input  logic [NCORES-1:0]       core_ready,
  output logic [NCORES-1:0]       core_msg_valid,
  output logic [MSG_W-1:0]        core_msg,
  input  logic [NCORES-1:0]       core_out_valid,
  input  logic [NCORES*MSG_W-1:0] core_digest,
  output logic                    found,
  output logic [MSG_W-1:0]        found_msg,
  output logic [2:0]              found_core,
  output logic                    busy
`ifdef MD5_SCHED_STATS_EN
  ,
  output logic [StatsW-1:0]       dispatched_cnt,
  output logic [StatsW-1:0]       completed_cnt
`endif
);

  sched_state_e      r_state;
  sched_state_e      w_state_d;
  logic [NCORES-1:0] r_in_flight;
  logic [NCORES-1:0] r_core_msg_valid;
  logic [MSG_W-1:0]  r_core_msg;
  logic [MSG_W-1:0]  r_target;
  logic [MSG_W-1:0]  r_found_msg;
  logic [2:0]        r_found_core;
  logic [MSG_W-1:0]  r_tag [NCORES];

  logic [NCORES-1:0] w_req;
  logic [NCORES-1:0] w_grant;
  logic [NCORES-1:0] w_accept;
  logic [NCORES-1:0] w_hit;
  logic              w_hit_any;
  logic [2:0]        w_hit_idx;
  logic [MSG_W-1:0]  w_hit_tag;
  logic              w_fire;
  logic              w_start_ok;

  assign w_req      = core_ready & ~r_in_flight;
  assign w_accept   = core_out_valid & r_in_flight;
  assign w_fire     = cand_valid & cand_ready;
  assign w_start_ok = (r_state == StIdle) && start && !clear;

  rr_arbiter #(
    .N(NCORES)
  ) u_rr_arbiter (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_req),
    .i_advance(w_fire),
    .o_grant  (w_grant)
  );

  // Every returning core is compared in the same cycle; the lowest index wins.
  always_comb begin
    w_hit     = '0;
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    w_hit_tag = '0;
    for (int i = 0; i < int'(NCORES); i++) begin
      w_hit[i] = w_accept[i] && (core_digest[i*MSG_W +: MSG_W] == r_target);
    end
    for (int i = int'(NCORES) - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = 3'(i);
        w_hit_tag = r_tag[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (clear) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (start) w_state_d = StRun;
        StRun:   if (w_hit_any) w_state_d = StDrain;
        StDrain: if (r_in_flight == '0) w_state_d = StFound;
        StFound: w_state_d = StFound;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cand_ready = 1'b0;
    busy       = 1'b0;
    found      = 1'b0;
    case (r_state)
      StRun: begin
        busy       = 1'b1;
        // A hit this cycle closes the stream immediately.
        cand_ready = (|w_req) && !w_hit_any && !clear;
      end
      StDrain: busy  = 1'b1;
      StFound: found = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_flight      <= '0;
      r_core_msg_valid <= '0;
      r_core_msg       <= '0;
      r_target         <= '0;
      r_found_msg      <= '0;
      r_found_core     <= '0;
    end else begin
      r_core_msg_valid <= w_fire ? w_grant : '0;
      if (w_fire) begin
        r_core_msg <= cand_data;
      end
      if (w_start_ok) begin
        r_target <= target;
      end
      if (clear) begin
        r_in_flight <= '0;
      end else begin
        r_in_flight <= (r_in_flight & ~w_accept) | (w_fire ? w_grant : '0);
      end
      if ((r_state == StRun) && w_hit_any && !clear) begin
        r_found_msg  <= w_hit_tag;
        r_found_core <= w_hit_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NCORES); i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NCORES); i++) begin
        if (w_fire && w_grant[i]) begin
          r_tag[i] <= cand_data;
        end
      end
    end
  end

  assign core_msg_valid = r_core_msg_valid;
  assign core_msg       = r_core_msg;
  assign found_msg      = r_found_msg;
  assign found_core     = r_found_core;

`ifdef MD5_SCHED_STATS_EN
  logic [StatsW-1:0] r_disp_cnt;
  logic [StatsW-1:0] r_comp_cnt;
  logic [StatsW:0]   w_comp_sum;

  assign w_comp_sum = {1'b0, r_comp_cnt} + (StatsW + 1)'(popcount(NCoresMax'(w_accept)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_cnt <= '0;
      r_comp_cnt <= '0;
    end else if (w_start_ok) begin
      r_disp_cnt <= '0;
      r_comp_cnt <= '0;
    end else begin
      if (w_fire && (r_disp_cnt != '1)) begin
        r_disp_cnt <= r_disp_cnt + 1'b1;
      end
      r_comp_cnt <= w_comp_sum[StatsW] ? '1 : w_comp_sum[StatsW-1:0];
    end
  end

  assign dispatched_cnt = r_disp_cnt;
  assign completed_cnt  = r_comp_cnt;
`endif

endmodule

// File: tb/tb_md5_core_scheduler.sv
// Self-checking bench for md5_core_scheduler: bench-side hash cores plus a cycle-level
// reference model of the dispatch/match rules; directed scenarios followed by random rounds.
`timescale 1ns/1ps
module tb_md5_core_scheduler;

  localparam int N = 2;
  localparam int W = 128;
  localparam logic [W-1:0] TGT = 128'h9ffaf8351cd571fabeb210c0170608ef;

  logic           clk = 1'b0;
  logic           reset, start, clear, cand_valid, cand_ready;
  logic [W-1:0]   target, cand_data, core_msg, found_msg;
  logic [N-1:0]   core_ready, core_msg_valid, core_out_valid;
  logic [N*W-1:0] core_digest;
  logic           found, busy;
  logic [2:0]     found_core;
`ifdef MD5_SCHED_STATS_EN
  logic [47:0]    dispatched_cnt, completed_cnt;
`endif

  always #5 clk = ~clk;

  md5_core_scheduler #(
    .NCORES(N),
    .MSG_W (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .clear         (clear),
    .target        (target),
    .cand_valid    (cand_valid),
    .cand_ready    (cand_ready),
    .cand_data     (cand_data),
    .core_ready    (core_ready),
    .core_msg_valid(core_msg_valid),
    .core_msg      (core_msg),
    .core_out_valid(core_out_valid),
    .core_digest   (core_digest),
    .found         (found),
    .found_msg     (found_msg),
    .found_core    (found_core),
    .busy          (busy)
`ifdef MD5_SCHED_STATS_EN
    ,
    .dispatched_cnt(dispatched_cnt),
    .completed_cnt (completed_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the scheduler.
  bit           m_search, m_wait, m_done;
  bit           m_inf [N];
  logic [W-1:0] m_tag [N];
  logic [W-1:0] m_target, m_fmsg, m_pulse_msg;
  int           m_last, m_fcore, m_pulse;
  longint       m_disp, m_comp;

  // Bench-side hash cores and stimulus controls.
  bit           c_busy [N];
  int           c_cnt [N];
  logic [W-1:0] c_msg [N];
  bit           hold, rnd_ready, rnd_valid, start_req, clear_req;
  int           lat_min, lat_max;
  logic [N-1:0] spur;
  logic [W-1:0] spur_dig, start_tgt, tgt;
  logic [W-1:0] cq [$];
  logic [W-1:0] cl [$];
  logic [N-1:0] plog [$];
  int           k, p;

  function automatic logic [W-1:0] hsh(input logic [W-1:0] m);
    if (m == 128'h41 || m == 128'h42) return TGT;
    return {m[63:0], ~m[127:64]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  function automatic logic [W-1:0] rand_cand();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[W-1] = 1'b1;
    return v;
  endfunction

  function automatic bit any_inf();
    for (int i = 0; i < N; i++) if (m_inf[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_cbusy();
    for (int i = 0; i < N; i++) if (c_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check cand_ready, advance the model.
  task automatic tick();
    logic [N-1:0]   exp_v, rdy, ov, deliv;
    logic [N*W-1:0] dg;
    int             hit_i, g, c;
    bit             exp_ready, free_any, drained;
    exp_v = (m_pulse >= 0) ? (N'(1) << m_pulse) : '0;
    chk("core_msg_valid", core_msg_valid, exp_v);
    if (m_pulse >= 0) chk("core_msg", core_msg, m_pulse_msg);
    chk("busy", busy, m_search || m_wait);
    chk("found", found, m_done);
    if (m_done) begin
      chk("found_core", found_core, m_fcore);
      chk("found_msg", found_msg, m_fmsg);
    end
`ifdef MD5_SCHED_STATS_EN
    chk("dispatched_cnt", dispatched_cnt, m_disp);
    chk("completed_cnt", completed_cnt, m_comp);
`endif
    if (core_msg_valid != '0) plog.push_back(core_msg_valid);
    for (int i = 0; i < N; i++) begin
      if (core_msg_valid[i]) begin
        c_busy[i] = 1'b1;
        c_msg[i]  = core_msg;
        c_cnt[i]  = int'($urandom_range(lat_max, lat_min));
      end
    end
    rdy = '0; ov = '0; dg = '0; deliv = '0;
    for (int i = 0; i < N; i++) begin
      if (c_busy[i] && !hold && c_cnt[i] == 0) begin
        ov[i] = 1'b1; deliv[i] = 1'b1; dg[i*W +: W] = hsh(c_msg[i]);
      end else if (spur[i] && !c_busy[i]) begin
        ov[i] = 1'b1; dg[i*W +: W] = spur_dig;
      end
      rdy[i] = !c_busy[i] && (!rnd_ready || $urandom_range(3, 0) != 0);
    end
    cand_valid     = (cq.size() > 0) && (!rnd_valid || $urandom_range(1, 0) == 1);
    cand_data      = (cq.size() > 0) ? cq[0] : '0;
    core_ready     = rdy;
    core_out_valid = ov;
    core_digest    = dg;
    start          = start_req;
    clear          = clear_req;
    target         = start_tgt;
    #1;
    hit_i = -1;
    for (int i = 0; i < N; i++)
      if (hit_i < 0 && ov[i] && m_inf[i] && dg[i*W +: W] == m_target) hit_i = i;
    free_any = 1'b0;
    for (int i = 0; i < N; i++) if (rdy[i] && !m_inf[i]) free_any = 1'b1;
    exp_ready = m_search && !clear_req && hit_i < 0 && free_any;
    chk("cand_ready", cand_ready, exp_ready);
    g = -1;
    for (int j = 1; j <= N; j++) begin
      c = (m_last + j) % N;
      if (g < 0 && rdy[c] && !m_inf[c]) g = c;
    end
    drained = !any_inf();
    m_pulse = -1;
    for (int i = 0; i < N; i++) if (ov[i] && m_inf[i]) m_comp++;
    if (clear_req) begin
      m_search = 0; m_wait = 0; m_done = 0;
      for (int i = 0; i < N; i++) m_inf[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) if (ov[i]) m_inf[i] = 0;
      if (m_wait && drained) begin
        m_wait = 0; m_done = 1;
      end else if (m_search && hit_i >= 0) begin
        m_fmsg = m_tag[hit_i]; m_fcore = hit_i; m_search = 0; m_wait = 1;
      end else if (exp_ready && cand_valid) begin
        m_tag[g] = cq[0]; m_inf[g] = 1; m_last = g; m_pulse = g;
        m_pulse_msg = cq.pop_front();
        m_disp++;
      end else if (!m_search && !m_wait && !m_done && start_req) begin
        m_search = 1; m_target = start_tgt; m_disp = 0; m_comp = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (deliv[i]) c_busy[i] = 0;
      else if (c_busy[i] && !hold && c_cnt[i] > 0) c_cnt[i]--;
    end
    @(posedge clk);
    #1;
    start_req = 0; clear_req = 0; spur = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; clear = 0; cand_valid = 0; core_ready = '0; core_out_valid = '0;
    #2;
    chk("rst_found", found, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cand_ready", cand_ready, 0);
    chk("rst_core_msg_valid", core_msg_valid, 0);
    chk("rst_core_msg", core_msg, 0);
    chk("rst_found_msg", found_msg, 0);
    chk("rst_found_core", found_core, 0);
    m_search = 0; m_wait = 0; m_done = 0; m_last = N - 1; m_pulse = -1;
    m_disp = 0; m_comp = 0;
    for (int i = 0; i < N; i++) m_inf[i] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [W-1:0] t);
    start_req = 1; start_tgt = t; tick();
  endtask

  task automatic do_clear();
    clear_req = 1; tick();
  endtask

  task automatic settle();
    for (int j = 0; j < 100 && any_cbusy(); j++) tick();
  endtask

  task automatic wait_found();
    for (int j = 0; j < 300 && !m_done; j++) tick();
    chk("found_reached", found, 1);
  endtask

  task automatic wait_both_busy();
    for (int j = 0; j < 30 && !(c_busy[0] && c_busy[1]); j++) tick();
    chk("both_dispatched", {c_busy[1], c_busy[0]}, 2'b11);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    hold = 0; rnd_ready = 0; rnd_valid = 0; start_req = 0; clear_req = 0;
    lat_min = 1; lat_max = 1; spur = '0; spur_dig = '0; start_tgt = '0;
    target = '0; cand_data = '0; core_digest = '0;
    m_target = '0; m_fmsg = '0; m_fcore = 0; m_pulse_msg = '0;
    for (int i = 0; i < N; i++) begin
      c_busy[i] = 0; c_cnt[i] = 0; c_msg[i] = '0; m_tag[i] = '0;
    end
    #1;
    do_reset();

    // Four back-to-back candidates with both cores ready alternate 01,10,01,10.
    do_start(rand_cand());
    plog.delete();
    for (int j = 0; j < 4; j++) cq.push_back(rand_cand());
    for (int j = 0; j < 60 && plog.size() < 4; j++) tick();
    chk("rr_count", plog.size(), 4);
    if (plog.size() >= 4) begin
      chk("rr_order0", plog[0], 2'b01);
      chk("rr_order1", plog[1], 2'b10);
      chk("rr_order2", plog[2], 2'b01);
      chk("rr_order3", plog[3], 2'b10);
    end
    settle();
    do_clear();

    // Core 1 returns the matching digest for 0x41.
    lat_min = 1; lat_max = 3;
    do_start(TGT);
    cq.push_back(128'h40);
    cq.push_back(128'h41);
    wait_found();
    chk("hit_found_core", found_core, 1);
    chk("hit_found_msg", found_msg, 128'h41);
    tick();
    do_clear();
    settle();
    chk("clear_found", found, 0);

    // Both cores return matching digests in the same cycle: core 0 wins.
    hold = 1;
    do_start(TGT);
    cq.push_back(128'h42);
    cq.push_back(128'h41);
    wait_both_busy();
    for (int i = 0; i < N; i++) c_cnt[i] = 0;
    hold = 0;
    wait_found();
    chk("tie_found_core", found_core, 0);
    chk("tie_found_msg", found_msg, 128'h42);
    do_clear();
    settle();

    // Results from cores with nothing in flight are ignored; late start ignored.
    do_start(TGT);
    spur = '1; spur_dig = TGT;
    tick();
    start_req = 1; start_tgt = 128'h5;
    tick();
    tick();
    chk("spur_found", found, 0);
    chk("spur_busy", busy, 1);
    start_req = 1; clear_req = 1;
    tick();
    chk("clear_beats_start", busy, 0);
    tick();

    // Reset with two candidates in flight; their later results are ignored.
    hold = 1;
    do_start(TGT);
    cq.push_back(128'h41);
    cq.push_back(128'h42);
    wait_both_busy();
    do_reset();
    hold = 0;
    for (int j = 0; j < 6; j++) tick();
    settle();
    chk("post_rst_found", found, 0);
    plog.delete();
    do_start(rand_cand());
    cq.push_back(rand_cand());
    for (int j = 0; j < 10 && plog.size() == 0; j++) tick();
    chk("post_rst_first_core", (plog.size() > 0) ? plog[0] : 2'b00, 2'b01);
    settle();
    do_clear();

`ifdef MD5_SCHED_STATS_EN
    do_start(rand_cand());
    for (int j = 0; j < 10; j++) cq.push_back(rand_cand());
    for (int j = 0; j < 200 && (cq.size() > 0 || any_cbusy()); j++) tick();
    tick();
    chk("stats_dispatched", dispatched_cnt, 10);
    chk("stats_completed", completed_cnt, 10);
    do_clear();
`endif

    // Random rounds: hit rounds and no-hit rounds with random readiness and latency.
    rnd_valid = 1; rnd_ready = 1; lat_min = 1; lat_max = 4;
    for (int r = 0; r < 8; r++) begin
      settle();
      cl.delete();
      k = int'($urandom_range(12, 5));
      p = (r % 2 == 0) ? int'($urandom_range(k - 1, 0)) : -1;
      for (int j = 0; j < k; j++) cl.push_back(rand_cand());
      tgt = (p >= 0) ? hsh(cl[p]) : rand_cand();
      do_start(tgt);
      for (int j = 0; j < k; j++) cq.push_back(cl[j]);
      for (int t = 0; t < 400; t++) begin
        if (m_done) break;
        if (p < 0 && cq.size() == 0 && !any_cbusy() && !any_inf()) break;
        if (t == 3) begin
          start_req = 1; start_tgt = hsh(cl[0]);
        end
        tick();
      end
      chk("rand_found", found, (p >= 0) ? 1'b1 : 1'b0);
      cq.delete();
      do_clear();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_core_scheduler.md
MD5_CORE_SCHEDULER -- requirements
Module: md5_core_scheduler

Interface
REQ-001 SHALL have parameter NCORES, default 2, number of hash cores sharing the candidate stream (range 1..8).
REQ-002 SHALL have parameter MSG_W, default 128, candidate/digest width in bits.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports start/clear  input  1 each  begin search / return to IDLE.
REQ-006 SHALL have port target  input  MSG_W  digest to match, sampled on start.
REQ-007 SHALL have ports cand_valid/cand_ready (in/out, 1) and cand_data (in, MSG_W)  candidate stream from generator.
REQ-008 SHALL have ports core_ready (in, NCORES), core_msg_valid (out, NCORES), core_msg (out, MSG_W, shared bus).
REQ-009 SHALL have ports core_out_valid (in, NCORES) and core_digest (in, NCORES*MSG_W, core i at slice i).
REQ-010 SHALL have ports found (out, 1), found_msg (out, MSG_W), found_core (out, 3), busy (out, 1).

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN, FOUND.
REQ-012 IDLE: start -> RUN, latch target; cand_ready=0, core_msg_valid=0.
REQ-013 RUN: cand_ready=1 iff at least one core has core_ready=1 and its slot is not in flight.
REQ-014 On cand_valid&cand_ready, SHALL pulse core_msg_valid[i] for exactly one cycle, the next cycle, with core_msg=cand_data; i chosen round-robin starting after the last granted core.
REQ-015 SHALL store the dispatched candidate in a per-core tag register and set in_flight[i]; no second dispatch to core i while in_flight[i]=1.
REQ-016 On core_out_valid[i] with in_flight[i]=1, SHALL compare core_digest slice i to target same cycle and clear in_flight[i]; core_out_valid[i] with in_flight[i]=0 SHALL be ignored.
REQ-017 Simultaneous core_out_valid on several cores: all SHALL be compared in that cycle; on multiple hits the lowest index wins; no result dropped.
REQ-018 On hit: found_msg<=tag[i], found_core<=i, -> DRAIN; no further dispatch.
REQ-019 DRAIN: wait until all in_flight=0 (late results ignored), then FOUND with found=1.
REQ-020 FOUND: hold outputs until clear; clear in any state -> IDLE next cycle, in_flight cleared, found=0.
REQ-021 busy SHALL be 1 in RUN and DRAIN.
REQ-022 start while not IDLE SHALL be ignored; start and clear in same cycle: clear wins.
REQ-023 Round-robin pointer SHALL wrap from NCORES-1 to 0.

Reset
REQ-024 Reset SHALL force IDLE, in_flight=0, RR pointer=0, found=0, found_msg=0, found_core=0, busy=0, cand_ready=0, core_msg_valid=0, core_msg=0.
REQ-025 Reset mid-search SHALL abandon in-flight candidates without any output pulse.

Configuration
REQ-026 With MD5_SCHED_STATS_EN defined, SHALL add outputs dispatched_cnt and completed_cnt (48 bits each), incremented per dispatch/per accepted result, saturating, cleared on reset and start.
REQ-027 Without MD5_SCHED_STATS_EN, ports and counters SHALL be absent; other behaviour identical.

Structure
REQ-028 State encoding, MSG_W default and NCORES maximum SHALL live in shared package md5_sched_pkg.
REQ-029 Round-robin grant SHALL be sub-module rr_arbiter (request vector, grant one-hot, advance).

Verification
REQ-030 NCORES=2, both ready, 4 candidates back-to-back -> core_msg_valid order 01,10,01,10 as cores return ready.
REQ-031 target=9ffaf8351cd571fabeb210c0170608ef returned by core 1 for candidate 0x...41 -> found=1, found_core=1, found_msg=0x...41 after DRAIN.
REQ-032 Both cores core_out_valid same cycle, both matching -> found_core=0.
REQ-033 core_out_valid on idle core (no in-flight) carrying matching digest -> found stays 0.
REQ-034 Reset asserted in RUN with 2 in flight -> next cycle all outputs at reset values; later results ignored.
REQ-035 MD5_SCHED_STATS_EN: 10 dispatches, 10 results, no hit -> dispatched_cnt=completed_cnt=10.
